// File: rtl/ula_issue.sv
// ula_issue: sequencing front-end for the 32-bit MIPS-style ALU.
// Accepts one instruction, decodes it into ALU OP/operands, captures the
// ALU result and Zero flag, and returns them on a valid/ready response.
module ula_issue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [OP_W-1:0]   ula_op,
    output logic [DATA_W-1:0] ula_in1,
    output logic [DATA_W-1:0] ula_in2,
    input  logic [DATA_W-1:0] ula_result,
    input  logic              ula_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_taken,
    output logic              out_illegal
);

    localparam int unsigned IMM_W = 16;

    // ALU OP codes
    localparam logic [OP_W-1:0] OP_AND = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(4'b0111);
    localparam logic [OP_W-1:0] OP_LUI = OP_W'(4'b1011);
    localparam logic [OP_W-1:0] OP_NOR = OP_W'(4'b1100);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4'b1101);
    localparam logic [OP_W-1:0] OP_SLL = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_SRL = OP_W'(4'b1111);

    // Opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_instr;
    logic [DATA_W-1:0]  r_rs;
    logic [DATA_W-1:0]  r_rt;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [OP_W-1:0]    r_ula_op;
    logic [DATA_W-1:0]  r_ula_in1;
    logic [DATA_W-1:0]  r_ula_in2;
    logic [DATA_W-1:0]  r_out_result;
    logic               r_out_zero;
    logic               r_out_taken;
    logic               r_out_illegal;

    logic [5:0]         w_opcode;
    logic [5:0]         w_funct;
    logic [DATA_W-1:0]  w_shamt_ext;
    logic [DATA_W-1:0]  w_imm_sext;
    logic [DATA_W-1:0]  w_imm_zext;
    logic [OP_W-1:0]    w_op;
    logic [DATA_W-1:0]  w_in1;
    logic [DATA_W-1:0]  w_in2;
    logic               w_illegal;
    logic               w_beq;
    logic               w_bne;
    logic               w_resp_fire;
    logic               w_unused_fields;

    assign w_opcode        = r_instr[31:26];
    assign w_funct         = r_instr[5:0];
    assign w_shamt_ext     = DATA_W'(r_instr[10:6]);
    assign w_imm_sext      = {{(DATA_W-IMM_W){r_instr[15]}}, r_instr[15:0]};
    assign w_imm_zext      = DATA_W'(r_instr[15:0]);
    assign w_resp_fire     = r_out_valid & out_ready;
    assign w_unused_fields = ^r_instr[25:16];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (in_valid) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_RESP;
            S_RESP:    if (w_resp_fire) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Decode latched instruction into ALU OP, operands and response flags
    always_comb begin
        w_op      = OP_ADD;
        w_in1     = '0;
        w_in2     = '0;
        w_illegal = 1'b0;
        w_beq     = 1'b0;
        w_bne     = 1'b0;
        case (w_opcode)
            OPC_RTYPE: begin
                case (w_funct)
                    FN_AND:          begin w_op = OP_AND; w_in1 = r_rs; w_in2 = r_rt; end
                    FN_OR:           begin w_op = OP_OR;  w_in1 = r_rs; w_in2 = r_rt; end
                    FN_ADD, FN_ADDU: begin w_op = OP_ADD; w_in1 = r_rs; w_in2 = r_rt; end
                    FN_SUB, FN_SUBU: begin w_op = OP_SUB; w_in1 = r_rs; w_in2 = r_rt; end
                    FN_SLT:          begin w_op = OP_SLT; w_in1 = r_rs; w_in2 = r_rt; end
                    FN_NOR:          begin w_op = OP_NOR; w_in1 = r_rs; w_in2 = r_rt; end
                    FN_XOR:          begin w_op = OP_XOR; w_in1 = r_rs; w_in2 = r_rt; end
                    FN_SLL:          begin w_op = OP_SLL; w_in1 = w_shamt_ext; w_in2 = r_rt; end
                    FN_SRL:          begin w_op = OP_SRL; w_in1 = w_shamt_ext; w_in2 = r_rt; end
                    FN_SLLV:         begin w_op = OP_SLL; w_in1 = r_rs; w_in2 = r_rt; end
                    FN_SRLV:         begin w_op = OP_SRL; w_in1 = r_rs; w_in2 = r_rt; end
                    default:         w_illegal = 1'b1;
                endcase
            end
            OPC_ADDI: begin w_op = OP_ADD; w_in1 = r_rs; w_in2 = w_imm_sext; end
            OPC_SLTI: begin w_op = OP_SLT; w_in1 = r_rs; w_in2 = w_imm_sext; end
            OPC_ANDI: begin w_op = OP_AND; w_in1 = r_rs; w_in2 = w_imm_zext; end
            OPC_ORI:  begin w_op = OP_OR;  w_in1 = r_rs; w_in2 = w_imm_zext; end
            OPC_XORI: begin w_op = OP_XOR; w_in1 = r_rs; w_in2 = w_imm_zext; end
            OPC_LUI:  begin w_op = OP_LUI; w_in1 = '0;   w_in2 = w_imm_zext; end
            OPC_BEQ:  begin w_op = OP_SUB; w_in1 = r_rs; w_in2 = r_rt; w_beq = 1'b1; end
            OPC_BNE:  begin w_op = OP_SUB; w_in1 = r_rs; w_in2 = r_rt; w_bne = 1'b1; end
            default:  w_illegal = 1'b1;
        endcase
    end

    // Handshake flags; out_valid rises one cycle into RESP and drops on the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (r_state == S_RESP) && !w_resp_fire;
        end
    end

    // Datapath: latch request, drive ALU operands, capture ALU response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr       <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_ula_op      <= OP_ADD;
            r_ula_in1     <= '0;
            r_ula_in2     <= '0;
            r_out_result  <= '0;
            r_out_zero    <= 1'b0;
            r_out_taken   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && in_valid) begin
                r_instr <= instr;
                r_rs    <= rs_data;
                r_rt    <= rt_data;
            end
            if (r_state == S_ISSUE) begin
                r_ula_op  <= w_op;
                r_ula_in1 <= w_in1;
                r_ula_in2 <= w_in2;
            end
            if (r_state == S_CAPTURE) begin
                r_out_result  <= w_illegal ? '0 : ula_result;
                r_out_zero    <= w_illegal | ula_zero;
                r_out_taken   <= !w_illegal && ((w_beq && ula_zero) || (w_bne && !ula_zero));
                r_out_illegal <= w_illegal;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign ula_op      = r_ula_op;
    assign ula_in1     = r_ula_in1;
    assign ula_in2     = r_ula_in2;
    assign out_result  = r_out_result;
    assign out_zero    = r_out_zero;
    assign out_taken   = r_out_taken;
    assign out_illegal = r_out_illegal;

endmodule

// File: doc/ula_issue.md
Name: ula_issue

Overview:
- Sequencing front-end for the 32-bit ALU in the MIPS-style datapath.
- Accepts one instruction per handshake and decodes opcode/funct into the ALU's 4-bit OP code.
- Selects and registers the ALU operands, then captures the ALU's combinational result and Zero flag.
- Returns a registered result, a branch decision and an illegal-instruction flag on a valid/ready output.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported (matches ALU).
- OP_W, 4, width of the ALU OP code.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction and operands present.
- in_ready  out  1  block can accept; high only in IDLE.
- instr  in  32  instruction word: [31:26] opcode, [10:6] shamt, [5:0] funct, [15:0] imm.
- rs_data  in  32  register rs value.
- rt_data  in  32  register rt value.
- ula_op  out  OP_W  OP code driven to the ALU.
- ula_in1  out  32  ALU In1.
- ula_in2  out  32  ALU In2.
- ula_result  in  32  ALU result (combinational from ula_op/in1/in2).
- ula_zero  in  1  ALU Zero flag.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts response.
- out_result  out  32  captured ALU result; 0 when illegal.
- out_zero  out  1  captured Zero flag.
- out_taken  out  1  branch decision: BEQ = zero, BNE = !zero, 0 otherwise.
- out_illegal  out  1  opcode/funct not decoded.

Behaviour:
- Reset (asynchronous, any state): state IDLE; in_ready=1; out_valid=0; ula_op=4'b0010; ula_in1=ula_in2=0; out_result=0; out_zero=0; out_taken=0; out_illegal=0. Any in-flight operation is discarded with no response.
- FSM:
  - IDLE: in_ready=1; on in_valid, latch instr/rs/rt, go to ISSUE.
  - ISSUE: drive registered ula_op/in1/in2 from decode; go to CAPTURE.
  - CAPTURE: register ula_result, ula_zero, taken and illegal into out_*; go to RESP.
  - RESP: out_valid=1; hold all out_* stable until out_ready; then return to IDLE.
- Latency: acceptance at edge N → out_valid high after edge N+3. Throughput is at most one instruction per 4 cycles.
- out_ready high during IDLE/ISSUE/CAPTURE is ignored. Back-to-back: in_ready returns high the cycle after the RESP handshake.
- ula_op/in1/in2 hold their last value outside ISSUE/CAPTURE.
- Decode, R-type (opcode 000000), funct → OP, In1, In2:
  - 100100 AND → 0000, rs, rt.
  - 100101 OR → 0001, rs, rt.
  - 100000 ADD and 100001 ADDU → 0010, rs, rt.
  - 100010 SUB and 100011 SUBU → 0110, rs, rt.
  - 101010 SLT → 0111, rs, rt.
  - 100111 NOR → 1100, rs, rt.
  - 100110 XOR → 1101, rs, rt.
  - 000000 SLL → 1110, In1={27'b0,shamt}, In2=rt.
  - 000010 SRL → 1111, In1={27'b0,shamt}, In2=rt.
  - 000100 SLLV → 1110, In1=rs, In2=rt.
  - 000110 SRLV → 1111, In1=rs, In2=rt.
- Decode, I-type (In1 = rs unless stated):
  - 001000 ADDI → 0010, In2=sign-ext imm.
  - 001010 SLTI → 0111, In2=sign-ext imm.
  - 001100 ANDI → 0000, In2=zero-ext imm.
  - 001101 ORI → 0001, In2=zero-ext imm.
  - 001110 XORI → 1101, In2=zero-ext imm.
  - 001111 LUI → 1011, In1=0, In2=zero-ext imm.
  - 000100 BEQ → 0110, In2=rt.
  - 000101 BNE → 0110, In2=rt.
- Any other opcode/funct: out_illegal=1; ula_op=0010; In1=In2=0; out_result=0; out_zero=1; out_taken=0.
- No overflow detection or trapping; the result wraps modulo 2^32. SLT/SLTI report the ALU's compare result unmodified.

Test Plan:
- Reset mid-operation: reset asserted while in CAPTURE → out_valid=0, in_ready=1 immediately; no response is produced after release.
- ADD: instr=0x00221820, rs=5, rt=7 → ula_op=0010, out_result=12, out_zero=0, out_valid on the 3rd edge after acceptance.
- LUI: instr=0x3C011234 → ula_op=1011, ula_in2=0x00001234, out_result=0x12340000.
- Shifts:
  - SLL shamt=4, rt=0x0000000F → ula_in1=4, out_result=0x000000F0.
  - SRLV rs=8, rt=0xFF00 → out_result=0x00FF.
- Branches:
  - BEQ rs=rt=0x55 → out_zero=1, out_taken=1.
  - BNE with the same operands → out_taken=0.
  - ADDI imm=0xFFFF, rs=1 → ula_in2=0xFFFFFFFF, out_result=0, out_zero=1.
- Illegal opcode 0x3F: out_illegal=1, out_result=0. Backpressure: out_ready low for 5 cycles → out_* stable, in_ready=0; in_ready returns high the cycle after out_ready.
